// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled decrement, one-cycle done pulse on expiry
// and optional auto-reload for periodic ticks.
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic [PW-1:0]    presc, presc_n;
  logic             done_n;
  logic             tick;

  // Control inputs are level-sampled every edge with fixed priority
  // load > stop > start > prescaler tick; there is no handshake back-pressure.
  assign tick = (state == RUN) && (presc == PMAX);
  assign busy = (state == RUN);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload_q;
    presc_n  = presc;
    done_n   = 1'b0;

    if (load) begin
      cnt_n    = din;
      reload_n = din;
      presc_n  = '0;
      state_n  = IDLE;
    end else if (stop) begin
      // In IDLE a stop swallows any simultaneous start.
      if (state == RUN) begin
        state_n = IDLE;
        presc_n = '0;
      end
    end else if (start && (state == IDLE)) begin
      if (cnt != '0) begin
        state_n = RUN;
        presc_n = '0;
      end else begin
        done_n = 1'b1;
      end
    end else if (state == RUN) begin
      if (tick) begin
        presc_n = '0;
        if (cnt > WIDTH'(1)) begin
          cnt_n = cnt - WIDTH'(1);
        end else if (cnt == WIDTH'(1)) begin
          done_n = 1'b1;
          if (auto_reload && (reload_q != '0)) begin
            cnt_n = reload_q;
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else begin
          // Unreachable in normal operation; never decrement from zero.
          state_n = IDLE;
        end
      end else begin
        presc_n = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      reload_q <= '0;
      presc    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      reload_q <= reload_n;
      presc    <= presc_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance at PRESCALE=4 and one at
// PRESCALE=1 share the same stimulus; each scenario checks the relevant one.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] din = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;

  logic [7:0] cnt4, cnt1;
  logic       busy4, busy1, done4, done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .din(din), .start(start), .stop(stop),
    .auto_reload(auto_reload), .cnt(cnt4), .busy(busy4), .done(done4)
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .din(din), .start(start), .stop(stop),
    .auto_reload(auto_reload), .cnt(cnt1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [7:0] v);
    din  = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic seen;

    // Reset
    rst = 1'b1;
    ticks(2);
    check("rst_cnt4", cnt4, 0);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_cnt1", cnt1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    rst = 1'b0;

    // Basic countdown, PRESCALE=4
    do_load(8'd3);
    check("basic_load_cnt", cnt4, 3);
    check("basic_load_busy", busy4, 0);
    do_start();
    check("basic_start_busy", busy4, 1);
    check("basic_start_cnt", cnt4, 3);
    ticks(3);
    check("basic_e3_cnt", cnt4, 3);
    tick();
    check("basic_e4_cnt", cnt4, 2);
    check("basic_e4_done", done4, 0);
    ticks(4);
    check("basic_e8_cnt", cnt4, 1);
    ticks(4);
    check("basic_e12_cnt", cnt4, 0);
    check("basic_e12_done", done4, 1);
    check("basic_e12_busy", busy4, 0);
    tick();
    check("basic_done_clear", done4, 0);

    // Pause / resume
    do_load(8'd5);
    do_start();
    ticks(5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("pause_cnt", cnt4, 4);
    check("pause_busy", busy4, 0);
    ticks(5);
    check("pause_hold_cnt", cnt4, 4);
    do_start();
    check("resume_busy", busy4, 1);
    ticks(3);
    check("resume_e3_cnt", cnt4, 4);
    tick();
    check("resume_e4_cnt", cnt4, 3);

    // start while running leaves the prescaler alone
    do_load(8'd2);
    do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("restart_e3_cnt", cnt4, 2);
    tick();
    check("restart_e4_cnt", cnt4, 1);
    ticks(4);
    check("restart_e8_done", done4, 1);
    check("restart_e8_cnt", cnt4, 0);

    // start and stop together from IDLE
    do_load(8'd3);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", busy4, 0);
    check("ss_cnt", cnt4, 3);
    check("ss_done", done4, 0);
    tick();
    check("ss_busy_later", busy4, 0);

    // Start with zero count: immediate expiry
    do_load(8'd0);
    do_start();
    check("zero_done4", done4, 1);
    check("zero_busy4", busy4, 0);
    check("zero_cnt4", cnt4, 0);
    check("zero_done1", done1, 1);
    tick();
    check("zero_done_clear", done4, 0);

    // Load mid-run halts the timer
    do_load(8'd9);
    do_start();
    ticks(8);
    check("midload_pre_cnt", cnt4, 7);
    check("midload_pre_busy", busy4, 1);
    do_load(8'h20);
    check("midload_cnt", cnt4, 8'h20);
    check("midload_busy", busy4, 0);
    check("midload_done", done4, 0);
    do_start();
    ticks(4);
    check("midload_run_cnt", cnt4, 8'h1f);

    // Auto-reload, PRESCALE=1
    auto_reload = 1'b1;
    do_load(8'd2);
    do_start();
    check("ar_start_busy", busy1, 1);
    check("ar_start_cnt", cnt1, 2);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("ar_cnt", cnt1, (i % 2) ? 1 : 2);
      check("ar_done", done1, (i % 2) ? 0 : 1);
      check("ar_busy", busy1, 1);
    end
    auto_reload = 1'b0;
    tick();
    check("ar_off_e7_cnt", cnt1, 1);
    check("ar_off_e7_busy", busy1, 1);
    tick();
    check("ar_off_e8_cnt", cnt1, 0);
    check("ar_off_e8_busy", busy1, 0);
    check("ar_off_e8_done", done1, 1);

    // Reset on the edge that would raise done
    do_load(8'd1);
    do_start();
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_done", done4, 0);
    check("rstmid_cnt", cnt4, 0);
    check("rstmid_busy", busy4, 0);

    // Full-range count at PRESCALE=1: done exactly 255 edges after start
    do_load(8'hff);
    do_start();
    seen = 1'b0;
    for (int i = 1; i <= 254; i++) begin
      tick();
      if (done1) seen = 1'b1;
    end
    check("ff_early_done", seen, 0);
    check("ff_e254_cnt", cnt1, 1);
    tick();
    check("ff_e255_done", done1, 1);
    check("ff_e255_cnt", cnt1, 0);
    check("ff_e255_busy", busy1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
